// File: rtl/div_arbiter_if.sv
// Requester request/response bundle plus the shared divider-side signals of div_arbiter.
interface div_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ*8-1:0] req_dividend_i;
    logic [NUM_REQ*8-1:0] req_divisor_i;
    logic [NUM_REQ-1:0]   rsp_valid_o;
    logic [31:0]          rsp_result_o;
    logic                 rsp_error_o;
    logic                 div_start_o;
    logic [7:0]           div_dividend_o;
    logic [7:0]           div_divisor_o;
    logic                 div_busy_i;
    logic                 div_finish_i;
    logic [8:0]           div_quotient_i;
    logic                 busy_o;

    modport slave (
        input  req_valid_i, req_dividend_i, req_divisor_i,
        input  div_busy_i, div_finish_i, div_quotient_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
        output div_start_o, div_dividend_o, div_divisor_o, busy_o
    );

    modport master (
        output req_valid_i, req_dividend_i, req_divisor_i,
        output div_busy_i, div_finish_i, div_quotient_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
        input  div_start_o, div_dividend_o, div_divisor_o, busy_o
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin share of one 8-bit sequential divider; DIV_ARB_ZERO_BYPASS_EN answers zero divisors locally.
// Latency: start held from T+1 until finish F (or timeout), response pulse at F+1, next grant at F+2.
// Backpressure: ready only in IDLE; responses are unbuffered one-cycle pulses.
module div_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    div_arbiter_if.slave bus
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      dividend_q, dividend_d;
    logic [7:0]      divisor_q, divisor_d;
    logic [31:0]     result_q, result_d;
    logic            error_q, error_d;

    logic [IDXW-1:0] grant;
    logic            grant_vld;
    logic            handshake;
    logic            zero_bypass;
    logic            timeout;
    logic [31:0]     mapped_quot;
    logic [7:0]      dd_arr [NUM_REQ];
    logic [7:0]      dv_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign dd_arr[k] = bus.req_dividend_i[8*k +: 8];
        assign dv_arr[k] = bus.req_divisor_i[8*k +: 8];
    end

    // First valid requester at or after ptr_q, wrapping.
    always_comb begin : grant_search
        logic [IDXW:0] sum;
        sum       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDXW+1)'(i);
            if (sum >= (IDXW+1)'(NUM_REQ)) begin
                sum = sum - (IDXW+1)'(NUM_REQ);
            end
            if (!grant_vld && bus.req_valid_i[sum[IDXW-1:0]]) begin
                grant_vld = 1'b1;
                grant     = sum[IDXW-1:0];
            end
        end
    end

    assign handshake   = (state_q == IDLE) && grant_vld;
    assign timeout     = (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
    assign mapped_quot = (bus.div_quotient_i == 9'h1FF) ? 32'hFFFF_FFFF
                                                        : {23'd0, bus.div_quotient_i};
`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign zero_bypass = (dv_arr[grant] == 8'h00);
`else
    assign zero_bypass = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = zero_bypass ? RESP : RUN;
            RUN:     if (bus.div_finish_i || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    ptr_d      = (grant == IDXW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    owner_d    = grant;
                    cnt_d      = '0;
                    dividend_d = dd_arr[grant];
                    divisor_d  = dv_arr[grant];
                    // Preloaded for the zero-divisor bypass; RUN overwrites it otherwise.
                    result_d   = 32'hFFFF_FFFF;
                    error_d    = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.div_finish_i) begin
                    result_d = mapped_quot;
                    error_d  = 1'b0;
                end else if (timeout) begin
                    result_d = 32'hFFFF_FFFF;
                    error_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        if (reset_ni && state_q == IDLE && grant_vld) begin
            bus.req_ready_o[grant] = 1'b1;
        end
        if (state_q == RESP) begin
            bus.rsp_valid_o[owner_q] = 1'b1;
        end
    end

    assign bus.div_start_o    = (state_q == RUN);
    assign bus.div_dividend_o = dividend_q;
    assign bus.div_divisor_o  = divisor_q;
    assign bus.rsp_result_o   = result_q;
    assign bus.rsp_error_o    = error_q;
    assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares the single 8-bit sequential divider between NUM_REQ requesters, for example the core and a second hart or accelerator port.
- Grants one request at a time, round-robin. Latches the operands and holds the divider start level until the divider reports finish.
- Maps the divider's 9-bit quotient to a 32-bit result and returns it with a one-cycle response pulse.
- A watchdog recovers from a divider that never finishes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum cycles in RUN before an error response.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot accept; a handshake completes when valid and ready are both high.
- req_dividend_i  in  NUM_REQ*8  packed dividends; requester k uses bits [8k+7:8k].
- req_divisor_i  in  NUM_REQ*8  packed divisors, same packing.
- rsp_valid_o  out  NUM_REQ  one-hot, one-cycle response pulse to the owning requester.
- rsp_result_o  out  32  shared result bus; valid only while any rsp_valid_o bit is high.
- rsp_error_o  out  1  qualifies the response as a timeout.
- div_start_o  out  1  start level to the divider.
- div_dividend_o  out  8  latched dividend.
- div_divisor_o  out  8  latched divisor.
- div_busy_i  in  1  divider busy (status only).
- div_finish_i  in  1  divider finish.
- div_quotient_i  in  9  divider quotient; 9'h1FF means divide-by-zero.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_ni low):
  - State IDLE, rr pointer 0, timeout counter 0.
  - All outputs 0, including operand and result registers.
  - Any in-flight operation is discarded and no response is issued for it.
  - div_start_o drops immediately.
- States: IDLE, RUN, RESP.
- IDLE:
  - Grant = first k with req_valid_i[k] set, searching from ptr upward with wrap-around.
  - req_ready_o[grant] = 1, combinational; all other ready bits are 0.
  - No request valid: stay in IDLE, ready = 0.
  - On handshake: latch the operands and owner index, set ptr = (grant+1) mod NUM_REQ, clear the counter, go to RUN.
- RUN:
  - div_start_o = 1 and the operand outputs are driven from the latches.
  - The counter increments each cycle.
  - req_ready_o = 0 for all requesters.
  - If div_finish_i = 1: latch the result (error 0), go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: result = 32'hFFFF_FFFF, error 1, go to RESP.
  - Finish and timeout in the same cycle: finish wins.
- Result mapping:
  - div_quotient_i == 9'h1FF gives 32'hFFFF_FFFF.
  - Any other quotient is zero-extended to 32 bits.
- RESP:
  - div_start_o = 0.
  - rsp_valid_o[owner] = 1 for exactly one cycle, with rsp_result_o and rsp_error_o driven from registers.
  - Always go to IDLE next. The start-low cycle re-arms the divider.
- Latency: handshake in cycle T, RUN from T+1. If finish arrives in cycle F, the response is in F+1 and the next grant is possible at F+2.
- Responses have no backpressure; requesters must sample the pulse.
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is legal and does not lose fairness state.
- Outputs rsp_*, div_start_o and busy_o are registered or decoded from state only; no combinational path from req_* to div_*.

Optional Feature:
- Macro: DIV_ARB_ZERO_BYPASS_EN.
- Defined: a granted request with divisor 8'h00 skips RUN.
  - IDLE goes straight to RESP with result 32'hFFFF_FFFF and error 0.
  - div_start_o is never asserted for it.
  - Response arrives at T+1.
- Undefined: zero divisors go through the divider like any other request; the 9'h1FF mapping produces the result.

Test Plan:
- Req0 dividend 20, divisor 3; divider stub finishes after 9 cycles with 9'h006 -> rsp_valid_o = 2'b01 pulse with rsp_result_o = 32'h0000_0006, error 0; div_start_o high exactly for the RUN cycles.
- Req0 and req1 valid in the same cycle from reset (ptr 0), continuously re-requesting -> grants alternate 0,1,0,1; each response pulse goes to the matching owner.
- Divisor 0:
  - Without the macro, stub returns 9'h1FF -> result 32'hFFFF_FFFF, error 0.
  - With DIV_ARB_ZERO_BYPASS_EN, response at T+1 and div_start_o stays low.
- Stub never asserts finish, TIMEOUT_CYCLES = 64 -> after 64 RUN cycles, response with error 1 and result 32'hFFFF_FFFF; the next request is then served normally.
- Finish asserted in the same cycle as the counter reaching 63 -> error 0 and the quotient result is returned.
- reset_ni pulsed low during RUN -> div_start_o, busy_o and all rsp_valid_o go to 0 immediately; no response pulse follows; ptr returns to 0.
